// File: rtl/sm4_key_expansion.sv
// rtl/sm4_key_expansion.sv - SM4 key schedule producing one round key per clock
module sm4_key_expansion (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic [4:0]   round_cnt,
  input  logic [31:0]  cki,
  output logic [31:0]  rk,
  output logic [4:0]   rk_idx,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  // GB/T 32907-2016 S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX[{~x, 3'b000} +: 8];
  endfunction

  state_t      state, state_nxt;
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] t_in, t_sub, t_out, rk_nxt;
  logic        last_round;

  assign last_round = (round_cnt == 5'd31);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)      state_nxt = RUN;
      RUN:     if (last_round) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // Round function T' = L'(tau(X)) with the key-schedule linear transform.
  always_comb begin
    t_in   = k1 ^ k2 ^ k3 ^ cki;
    t_sub  = {sbox(t_in[31:24]), sbox(t_in[23:16]), sbox(t_in[15:8]), sbox(t_in[7:0])};
    t_out  = t_sub ^ {t_sub[18:0], t_sub[31:19]} ^ {t_sub[8:0], t_sub[31:9]};
    rk_nxt = k0 ^ t_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k0        <= '0;
      k1        <= '0;
      k2        <= '0;
      k3        <= '0;
      round_cnt <= '0;
      rk        <= '0;
      rk_idx    <= '0;
      rk_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            {k0, k1, k2, k3} <= key ^ FK;
            round_cnt        <= '0;
          end
        end
        RUN: begin
          k0        <= k1;
          k1        <= k2;
          k2        <= k3;
          k3        <= rk_nxt;
          rk        <= rk_nxt;
          rk_idx    <= round_cnt;
          rk_valid  <= 1'b1;
          done      <= last_round;
          round_cnt <= last_round ? 5'd0 : round_cnt + 5'd1;
        end
        default: round_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_key_expansion.sv
// tb/tb_sm4_key_expansion.sv - scoreboard bench for the SM4 key schedule
module tb_sm4_key_expansion;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic [4:0]   round_cnt;
  logic [31:0]  cki;
  logic [31:0]  rk;
  logic [4:0]   rk_idx;
  logic         rk_valid;
  logic         busy;
  logic         done;

  typedef struct packed {
    logic [31:0] rk;
    logic [4:0]  idx;
  } exp_t;

  localparam logic [127:0] KEY_STD = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] FK_TB   = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
  localparam logic [2047:0] SBOX_TB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;

  exp_t        exp_q[$];
  logic [31:0] cap_rk[$];
  logic [4:0]  cap_idx[$];
  logic        cap_done[$];
  int          cap_edge[$];
  int          stray_done = 0;

  sm4_key_expansion dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .round_cnt (round_cnt),
    .cki       (cki),
    .rk        (rk),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ck_of(input int i);
    logic [31:0] r;
    logic [7:0]  v;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      v = 8'((4 * i + j) * 7);
      r = {r[23:0], v};
    end
    return r;
  endfunction

  assign cki = ck_of(int'(round_cnt));

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX_TB[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic void model_expand(input logic [127:0] mk);
    logic [31:0] k[36];
    logic [31:0] x, b;
    exp_t        e;
    {k[0], k[1], k[2], k[3]} = mk ^ FK_TB;
    for (int i = 0; i < 32; i++) begin
      x = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_of(i);
      b = {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
      k[i+4] = k[i] ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
      e.rk  = k[i+4];
      e.idx = 5'(i);
      exp_q.push_back(e);
    end
  endfunction

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  always @(negedge clk) begin
    if (rk_valid === 1'b1) begin
      cap_rk.push_back(rk);
      cap_idx.push_back(rk_idx);
      cap_done.push_back(done);
      cap_edge.push_back(edge_cnt);
    end else if (done === 1'b1) begin
      stray_done = stray_done + 1;
    end
  end

  task automatic clear_cap();
    exp_q.delete();
    cap_rk.delete();
    cap_idx.delete();
    cap_done.delete();
    cap_edge.delete();
    stray_done = 0;
  endtask

  task automatic launch(input logic [127:0] k, output int e0);
    @(posedge clk); #1;
    key   = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e0    = edge_cnt;
  endtask

  task automatic wait_dones(input int need, input int limit, output bit ok);
    int n;
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk); #1;
      n = 0;
      foreach (cap_done[i]) if (cap_done[i]) n++;
      if (n >= need) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({round_cnt, rk, rk_idx, rk_valid, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got cnt=%h rk=%h idx=%h v=%b busy=%b done=%b, expected all zero",
               round_cnt, rk, rk_idx, rk_valid, busy, done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_vector();
    int   e0;
    bit   ok;
    exp_t e;
    clear_cap();
    model_expand(KEY_STD);
    launch(KEY_STD, e0);
    wait_dones(1, 60, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL vec_timeout: no done within 60 cycles"); end
    tests++;
    if (busy !== 1'b0 || round_cnt !== 5'd0) begin
      fails++; $display("FAIL vec_done_idle: busy=%b cnt=%0d, expected 0/0", busy, round_cnt);
    end
    tests++;
    if (cap_rk.size() != 32) begin fails++; $display("FAIL vec_count: got %0d keys, expected 32", cap_rk.size()); end
    for (int i = 0; i < 32; i++) begin
      e = exp_q.pop_front();
      tests++;
      if (i >= cap_rk.size() || cap_rk[i] !== e.rk || cap_idx[i] !== e.idx || cap_done[i] !== (i == 31)) begin
        fails++;
        if (i < cap_rk.size())
          $display("FAIL vec_key%0d: got rk=%h idx=%0d done=%b, expected rk=%h idx=%0d done=%b",
                   i, cap_rk[i], cap_idx[i], cap_done[i], e.rk, e.idx, (i == 31));
        else
          $display("FAIL vec_key%0d: missing, expected rk=%h", i, e.rk);
      end
    end
    tests++;
    if (cap_rk.size() != 32 || cap_rk[0] !== 32'hF12186F9 || cap_rk[1] !== 32'h41662B61 || cap_rk[31] !== 32'h9124A012) begin
      fails++; $display("FAIL vec_known: rk0/rk1/rk31 differ from F12186F9/41662B61/9124A012");
    end
    tests++;
    if (cap_rk.size() != 32 || cap_edge[0] != e0 + 1 || cap_edge[31] != e0 + 32) begin
      fails++; $display("FAIL vec_timing: rk0/rk31 edges off, expected start+1 and start+32");
    end
    repeat (3) @(negedge clk);
    tests++;
    if (rk !== 32'h9124A012 || rk_idx !== 5'd31 || rk_valid !== 1'b0 || stray_done != 0) begin
      fails++; $display("FAIL vec_hold: got rk=%h idx=%0d v=%b stray=%0d, expected 9124a012/31/0/0",
                        rk, rk_idx, rk_valid, stray_done);
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    int   ndone;
    exp_t e;
    clear_cap();
    model_expand(KEY_STD);
    model_expand(KEY_STD);
    @(posedge clk); #1;
    key   = KEY_STD;
    start = 1'b1;
    repeat (40) @(posedge clk);
    #1 start = 1'b0;
    wait_dones(2, 100, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_timeout: fewer than 2 done pulses"); end
    repeat (40) @(negedge clk);
    tests++;
    if (cap_rk.size() != 64) begin fails++; $display("FAIL b2b_count: got %0d keys, expected 64", cap_rk.size()); end
    ndone = 0;
    for (int i = 0; i < 64; i++) begin
      e = exp_q.pop_front();
      tests++;
      if (i >= cap_rk.size() || cap_rk[i] !== e.rk || cap_idx[i] !== e.idx) begin
        fails++;
        $display("FAIL b2b_key%0d: expected rk=%h idx=%0d", i, e.rk, e.idx);
      end else if (cap_done[i]) ndone++;
    end
    tests++;
    if (ndone != 2 || cap_rk.size() != 64 || !cap_done[31] || cap_edge[32] != cap_edge[31] + 2) begin
      fails++; $display("FAIL b2b_restart: dones=%0d, second run must start on the done cycle", ndone);
    end
  endtask

  task automatic test_reset_mid_run();
    int   e0;
    bit   ok;
    exp_t e;
    clear_cap();
    launch(KEY_STD, e0);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (rk_valid === 1'b1 && rk_idx === 5'd15) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL rst_mid_reach: rk_idx 15 never presented"); end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({round_cnt, rk, rk_idx, rk_valid, busy, done} !== '0) begin
      fails++;
      $display("FAIL rst_mid_outputs: got cnt=%h rk=%h idx=%h v=%b busy=%b done=%b, expected all zero",
               round_cnt, rk, rk_idx, rk_valid, busy, done);
    end
    #1 rst_n = 1'b1;
    repeat (50) @(negedge clk);
    tests++;
    if (cap_rk.size() != 16 || stray_done != 0 || cap_done[15] !== 1'b0) begin
      fails++; $display("FAIL rst_mid_quiet: got %0d keys after reset, expected 16 and no done", cap_rk.size());
    end
    clear_cap();
    model_expand(KEY_STD);
    launch(KEY_STD, e0);
    wait_dones(1, 60, ok);
    tests++;
    if (!ok || cap_rk.size() != 32) begin fails++; $display("FAIL rst_restart_count: got %0d keys, expected 32", cap_rk.size()); end
    for (int i = 0; i < 32; i++) begin
      e = exp_q.pop_front();
      tests++;
      if (i >= cap_rk.size() || cap_rk[i] !== e.rk || cap_idx[i] !== e.idx) begin
        fails++; $display("FAIL rst_restart_key%0d: expected rk=%h idx=%0d", i, e.rk, e.idx);
      end
    end
  endtask

  task automatic test_key_change_busy();
    int   e0;
    bit   ok;
    exp_t e;
    clear_cap();
    model_expand(KEY_STD);
    launch(KEY_STD, e0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    key   = '1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_dones(1, 60, ok);
    repeat (10) @(negedge clk);
    tests++;
    if (!ok || cap_rk.size() != 32) begin fails++; $display("FAIL busy_count: got %0d keys, expected 32", cap_rk.size()); end
    for (int i = 0; i < 32; i++) begin
      e = exp_q.pop_front();
      tests++;
      if (i >= cap_rk.size() || cap_rk[i] !== e.rk || cap_idx[i] !== e.idx) begin
        fails++; $display("FAIL busy_key%0d: expected rk=%h idx=%0d", i, e.rk, e.idx);
      end
    end
    key = KEY_STD;
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      tests++;
      if (round_cnt !== 5'd0 || busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0) begin
        fails++;
        if (bad++ < 3)
          $display("FAIL idle_cycle%0d: got cnt=%0d busy=%b v=%b done=%b, expected all zero",
                   c, round_cnt, busy, rk_valid, done);
      end
    end
  endtask

  task automatic test_random_keys();
    int           e0;
    bit           ok;
    exp_t         e;
    logic [127:0] k;
    for (int r = 0; r < 4; r++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      clear_cap();
      model_expand(k);
      launch(k, e0);
      wait_dones(1, 60, ok);
      tests++;
      if (!ok || cap_rk.size() != 32) begin fails++; $display("FAIL rand%0d_count: got %0d keys, expected 32", r, cap_rk.size()); end
      for (int i = 0; i < 32; i++) begin
        e = exp_q.pop_front();
        tests++;
        if (i >= cap_rk.size() || cap_rk[i] !== e.rk || cap_idx[i] !== e.idx) begin
          fails++; $display("FAIL rand%0d_key%0d: key=%h expected rk=%h", r, i, k, e.rk);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key   = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_vector();
    test_back_to_back();
    test_reset_mid_run();
    test_key_change_busy();
    test_idle();
    test_random_keys();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
